// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate generation stage: immediate format
// encodings and the legal datapath widths, also used by the control decoder.
package imm_gen_stage_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_ZIMM  = 3'b101,
        IMM_SHAMT = 3'b110,
        IMM_ILL   = 3'b111
    } imm_src_e;

    localparam int unsigned XLEN_32 = 32;
    localparam int unsigned XLEN_64 = 64;

    function automatic logic xlen_legal(input int unsigned xlen);
        return (xlen == XLEN_32) || (xlen == XLEN_64);
    endfunction

endpackage

// File: rtl/imm_ext_fmt.sv
// Combinational immediate extraction and extension for one instruction word.
module imm_ext_fmt
    import imm_gen_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Signed formats start from a sign fill and then overwrite the low bits.
    always_comb begin
        imm = '0;
        err = 1'b0;
        unique case (imm_src)
            IMM_I: begin
                imm       = {XLEN{instr[31]}};
                imm[11:0] = instr[31:20];
            end
            IMM_S: begin
                imm       = {XLEN{instr[31]}};
                imm[11:0] = {instr[31:25], instr[11:7]};
            end
            IMM_B: begin
                imm       = {XLEN{instr[31]}};
                imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            IMM_U: begin
                imm       = {XLEN{instr[31]}};
                imm[31:0] = {instr[31:12], 12'b0};
            end
            IMM_J: begin
                imm       = {XLEN{instr[31]}};
                imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            IMM_ZIMM: begin
                imm[4:0] = instr[19:15];
            end
            IMM_SHAMT: begin
                if (XLEN == XLEN_64) begin
                    imm[5:0] = instr[25:20];
                end else begin
                    imm[4:0] = instr[24:20];
                end
            end
            IMM_ILL: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate generation pipeline stage: extends the immediate at the input side
// and holds results in a two-entry skid buffer (output register + skid register).
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [31:0]      instr_q,
    output logic             imm_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [XLEN-1:0]  new_imm;
    logic             new_err;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic             out_err_q, out_err_d;

    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [31:0]      skid_instr_q, skid_instr_d;
    logic             skid_err_q, skid_err_d;

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             in_xfer;
    logic             out_xfer;

    imm_ext_fmt #(
        .XLEN (XLEN)
    ) u_imm_ext_fmt (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (new_imm),
        .err     (new_err)
    );

    // in_ready comes straight from the skid flop, so out_ready never reaches it.
    assign in_ready  = ~skid_valid_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid_q & out_ready;

    assign out_valid = out_valid_q;
    assign imm_ext   = out_imm_q;
    assign instr_q   = out_instr_q;
    assign imm_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_instr_d  = out_instr_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_instr_d = skid_instr_q;
        skid_err_d   = skid_err_q;
        err_cnt_d    = err_cnt_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (!out_valid_q || out_xfer) begin
                // Output register is free this edge: refill from skid first to keep order.
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_imm_d    = skid_imm_q;
                    out_instr_d  = skid_instr_q;
                    out_err_d    = skid_err_q;
                    skid_valid_d = in_xfer;
                    if (in_xfer) begin
                        skid_imm_d   = new_imm;
                        skid_instr_d = instr;
                        skid_err_d   = new_err;
                    end
                end else begin
                    out_valid_d = in_xfer;
                    if (in_xfer) begin
                        out_imm_d   = new_imm;
                        out_instr_d = instr;
                        out_err_d   = new_err;
                    end
                end
            end else if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_imm_d   = new_imm;
                skid_instr_d = instr;
                skid_err_d   = new_err;
            end

            if (in_xfer && new_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_instr_q  <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_instr_q <= '0;
            skid_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_instr_q  <= out_instr_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_instr_q <= skid_instr_d;
            skid_err_q   <= skid_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomised bench for imm_gen_stage: a 32-bit instance with a 2-bit error
// counter and a 64-bit instance share stimulus and are checked against a queue model.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  imm_src;

    logic        a_in_ready, a_out_valid, a_imm_err;
    logic [31:0] a_imm_ext, a_instr_q;
    logic [1:0]  a_err_cnt;

    logic        b_in_ready, b_out_valid, b_imm_err;
    logic [63:0] b_imm_ext;
    logic [31:0] b_instr_q;
    logic [15:0] b_err_cnt;

    imm_gen_stage #(.XLEN(32), .CNT_W(2)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .instr     (instr),
        .imm_src   (imm_src),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .imm_ext   (a_imm_ext),
        .instr_q   (a_instr_q),
        .imm_err   (a_imm_err),
        .err_cnt   (a_err_cnt)
    );

    imm_gen_stage #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .instr     (instr),
        .imm_src   (imm_src),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .imm_ext   (b_imm_ext),
        .instr_q   (b_instr_q),
        .imm_err   (b_imm_err),
        .err_cnt   (b_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference immediate from the format table, using signed arithmetic for sign fill.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input bit x64);
        logic signed [63:0] r;
        case (src)
            3'd0: r = $signed(ins[31:20]);
            3'd1: r = $signed({ins[31:25], ins[11:7]});
            3'd2: r = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            3'd3: r = $signed({ins[31:12], 12'b0});
            3'd4: r = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            3'd5: r = {59'd0, ins[19:15]};
            3'd6: r = x64 ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
            default: r = '0;
        endcase
        if (!x64) r = {32'd0, r[31:0]};
        return r;
    endfunction

    // Model: in-order queue of at most two accepted instructions.
    logic [31:0] q_instr[$];
    logic [2:0]  q_src[$];
    int          cnt_a = 0;
    int          cnt_b = 0;

    task automatic model_step();
        bit acc;
        if (rst) begin
            q_instr.delete();
            q_src.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            acc = in_valid && (q_instr.size() < 2);
            if (flush) begin
                q_instr.delete();
                q_src.delete();
            end else begin
                if (q_instr.size() > 0 && out_ready) begin
                    void'(q_instr.pop_front());
                    void'(q_src.pop_front());
                end
                if (acc) begin
                    q_instr.push_back(instr);
                    q_src.push_back(imm_src);
                    if (imm_src == 3'd7) begin
                        if (cnt_a < 3) cnt_a++;
                        if (cnt_b < 65535) cnt_b++;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("in_ready32", a_in_ready, q_instr.size() < 2);
                check("in_ready64", b_in_ready, q_instr.size() < 2);
                check("out_valid32", a_out_valid, q_instr.size() > 0);
                check("out_valid64", b_out_valid, q_instr.size() > 0);
                check("err_cnt32", a_err_cnt, 64'(cnt_a));
                check("err_cnt64", b_err_cnt, 64'(cnt_b));
                if (q_instr.size() > 0) begin
                    check("instr_q32", a_instr_q, q_instr[0]);
                    check("instr_q64", b_instr_q, q_instr[0]);
                    check("imm_ext32", {32'd0, a_imm_ext}, ref_imm(q_instr[0], q_src[0], 1'b0));
                    check("imm_ext64", b_imm_ext, ref_imm(q_instr[0], q_src[0], 1'b1));
                    check("imm_err32", a_imm_err, q_src[0] == 3'd7);
                    check("imm_err64", b_imm_err, q_src[0] == 3'd7);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input bit v, input logic [31:0] i, input logic [2:0] s);
        in_valid = v;
        instr    = i;
        imm_src  = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] lst[4];
        logic [31:0] got[$];
        logic [31:0] r;
        int          exp_cnt[5] = '{1, 2, 3, 3, 3};
        int          idx, cycles, seen;
        bit          xin, xout;

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'd0, 3'd0);
        #1;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_imm_ext", b_imm_ext, 0);
        check("rst_err_cnt", a_err_cnt, 0);
        cyc();
        cyc();
        rst = 1'b0;

        // I format, 32 and 64 bits
        out_ready = 1'b1;
        set_in(1'b1, 32'hFFF00093, 3'd0);
        cyc();
        set_in(1'b0, 32'd0, 3'd0);
        check("i_valid", a_out_valid, 1);
        check("i_imm32", a_imm_ext, 32'hFFFF_FFFF);
        check("i_err", a_imm_err, 0);
        check("i_imm64", b_imm_ext, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();

        // S format, then U format with 64-bit sign fill
        set_in(1'b1, 32'hFE112E23, 3'd1);
        cyc();
        check("s_imm32", a_imm_ext, 32'hFFFF_FFFC);
        set_in(1'b1, 32'h80000537, 3'd3);
        cyc();
        check("u_imm64", b_imm_ext, 64'hFFFF_FFFF_8000_0000);
        check("u_imm32", a_imm_ext, 32'h8000_0000);
        set_in(1'b0, 32'd0, 3'd0);
        cyc();

        // Illegal format saturates the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            r = $urandom;
            set_in(1'b1, r, 3'd7);
            cyc();
            check("ill_cnt", a_err_cnt, 64'(exp_cnt[k]));
            check("ill_imm", a_imm_ext, 0);
            check("ill_err", a_imm_err, 1);
            check("ill_instr", a_instr_q, r);
        end
        set_in(1'b0, 32'd0, 3'd0);
        check("ill_cnt64", b_err_cnt, 5);
        cyc();

        // Four instructions against a three-cycle stall
        for (int k = 0; k < 4; k++) lst[k] = $urandom;
        out_ready = 1'b0;
        idx = 0;
        cycles = 0;
        while ((idx < 4 || got.size() < 4) && cycles < 40) begin
            out_ready = (cycles >= 3);
            set_in(idx < 4, lst[idx < 4 ? idx : 0], 3'd0);
            xin  = in_valid && a_in_ready;
            xout = a_out_valid && out_ready;
            if (xout) got.push_back(a_instr_q);
            cyc();
            cycles++;
            if (xin) idx++;
            if (cycles == 1) check("stall_ready1", a_in_ready, 1);
            if (cycles == 2) check("stall_ready2", a_in_ready, 0);
        end
        check("stall_count", got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) check("stall_order", got[k], lst[k]);
        end
        set_in(1'b0, 32'd0, 3'd0);
        cyc();

        // Flush with skid full and a same-cycle input
        out_ready = 1'b0;
        set_in(1'b1, $urandom, 3'd0);
        cyc();
        set_in(1'b1, $urandom, 3'd2);
        cyc();
        check("full_ready", a_in_ready, 0);
        flush = 1'b1;
        set_in(1'b1, $urandom, 3'd4);
        cyc();
        flush = 1'b0;
        set_in(1'b0, 32'd0, 3'd0);
        check("flush_valid", a_out_valid, 0);
        check("flush_ready", a_in_ready, 1);
        out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            cyc();
            if (a_out_valid) seen++;
        end
        check("flush_ghost", seen, 0);

        // Random traffic
        repeat (800) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            instr     = $urandom;
            imm_src   = 3'($urandom_range(0, 7));
            cyc();
        end
        flush = 1'b0;

        // Asynchronous reset during a stall
        out_ready = 1'b0;
        set_in(1'b1, $urandom, 3'd7);
        cyc();
        set_in(1'b1, $urandom, 3'd1);
        cyc();
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", a_out_valid, 0);
        check("arst_ready", a_in_ready, 1);
        check("arst_imm32", a_imm_ext, 0);
        check("arst_instr", a_instr_q, 0);
        check("arst_err", a_imm_err, 0);
        check("arst_cnt32", a_err_cnt, 0);
        check("arst_cnt64", b_err_cnt, 0);
        check("arst_imm64", b_imm_ext, 0);
        set_in(1'b0, 32'd0, 3'd0);
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        set_in(1'b1, 32'h00500113, 3'd0);
        cyc();
        set_in(1'b0, 32'd0, 3'd0);
        check("post_rst_valid", a_out_valid, 1);
        check("post_rst_imm", a_imm_ext, 5);
        check("post_rst_instr", a_instr_q, 32'h00500113);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
